// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready stream feeding the UART transmitter.
// The producer drives DATA/VALID; the transmitter returns READY.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] DATA;
    logic                 VALID;
    logic                 READY;

    modport master (output DATA, output VALID, input READY);
    modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/uart_tx.sv
// Asynchronous-frame serial transmitter: start bit, DATA_BITS LSB first, STOP_BITS stop bits,
// each bit held for one BAUD_TICK period. Words enter through a valid/ready stream.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic      CLK,
    input  logic      RESETN,
    input  logic      BAUD_TICK,
    uart_tx_if.slave  s,
    output logic      TX,
    output logic      BUSY
);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [CW-1:0]        bitcnt, bitcnt_n;
    logic [1:0]           stopcnt, stopcnt_n;
    logic                 tx_q, tx_n;
    logic                 ready_q, ready_n;

    // Control state resets; the shift register only carries payload and is
    // always reloaded on acceptance, so it is left out of reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= S_IDLE;
            bitcnt  <= '0;
            stopcnt <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            bitcnt  <= bitcnt_n;
            stopcnt <= stopcnt_n;
            tx_q    <= tx_n;
            ready_q <= ready_n;
        end
        shift <= shift_n;
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bitcnt_n  = bitcnt;
        stopcnt_n = stopcnt;
        tx_n      = tx_q;
        ready_n   = ready_q;
        case (state)
            S_IDLE: begin
                tx_n    = 1'b1;
                ready_n = 1'b1;
                // A tick coinciding with acceptance is deliberately not looked at here.
                if (s.VALID && ready_q) begin
                    shift_n = s.DATA;
                    ready_n = 1'b0;
                    state_n = S_ARMED;
                end
            end
            S_ARMED: begin
                if (BAUD_TICK) begin
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (BAUD_TICK) begin
                    tx_n     = shift[0];
                    shift_n  = shift >> 1;
                    bitcnt_n = CW'(1);
                    state_n  = S_DATA;
                end
            end
            S_DATA: begin
                if (BAUD_TICK) begin
                    if (bitcnt < CW'(DATA_BITS)) begin
                        tx_n     = shift[0];
                        shift_n  = shift >> 1;
                        bitcnt_n = bitcnt + CW'(1);
                    end else begin
                        tx_n      = 1'b1;
                        stopcnt_n = 2'd1;
                        state_n   = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (BAUD_TICK) begin
                    if (stopcnt < 2'(STOP_BITS)) begin
                        stopcnt_n = stopcnt + 2'd1;
                    end else begin
                        ready_n = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign TX      = tx_q;
    assign s.READY = ready_q;
    assign BUSY    = (state != S_IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits), randomized tick patterns and words,
// expected words queued on acceptance and checked bit by bit by a line-decoding monitor.
module tb_uart_tx;
    localparam int DB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic tick0, tick1;
    logic tx0, tx1, busy0, busy1;

    uart_tx_if #(.DATA_BITS(DB)) if0 ();
    uart_tx_if #(.DATA_BITS(DB)) if1 ();

    uart_tx #(.DATA_BITS(DB), .STOP_BITS(1)) u0 (
        .CLK(clk), .RESETN(rstn), .BAUD_TICK(tick0), .s(if0.slave), .TX(tx0), .BUSY(busy0)
    );
    uart_tx #(.DATA_BITS(DB), .STOP_BITS(2)) u1 (
        .CLK(clk), .RESETN(rstn), .BAUD_TICK(tick1), .s(if1.slave), .TX(tx1), .BUSY(busy1)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, id, $time, act, exp);
        end
    endtask

    // ---------------- tick generation ----------------
    int mode[2];   // 0 periodic, 1 tied high, 2 random
    int per[2];
    int tcnt[2];

    function automatic logic gen_tick(input int id);
        if (mode[id] == 1) return 1'b1;
        if (mode[id] == 2) return ($urandom_range(0, 3) == 0);
        tcnt[id]++;
        return (tcnt[id] % per[id] == 0);
    endfunction

    initial begin
        tick0 = 1'b0;
        tick1 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tick0 = gen_tick(0);
            tick1 = gen_tick(1);
        end
    end

    // ---------------- reference model: expected words ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic push_exp(input int id, input logic [7:0] d);
        if (id == 0) q0.push_back(d); else q1.push_back(d);
    endtask

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    // ---------------- edge sampler ----------------
    int cyc = 0;
    bit acc_s[2];
    bit tk_s[2];
    bit rs_s;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rs_s     = !rstn;
            acc_s[0] = rstn && if0.VALID && if0.READY;
            acc_s[1] = rstn && if1.VALID && if1.READY;
            tk_s[0]  = tick0;
            tk_s[1]  = tick1;
        end
    end

    // ---------------- monitor: decode line per tick period ----------------
    int st[2];        // 0 idle, 1 start/data, 2 stop
    int idx[2];
    int sidx[2];
    int tsince[2];
    int frames[2];
    int start_cyc[2];
    int last_len[2];
    bit lvl[2], pend[2], havep[2], live[2];
    logic [7:0] cur[2];

    task automatic mon_step(input int id, input logic tx, input logic rdy, input logic bsy, input int sb);
        bit eff;
        if (rs_s) begin
            chk("rst_tx", id, 32'(tx), 1);
            chk("rst_ready", id, 32'(rdy), 1);
            chk("rst_busy", id, 32'(bsy), 0);
            st[id] = 0; pend[id] = 0; lvl[id] = 1'b1; havep[id] = 0; live[id] = 1;
            if (id == 0) q0.delete(); else q1.delete();
            return;
        end
        if (!live[id]) return;
        eff = tk_s[id] && !acc_s[id];
        if (acc_s[id]) begin
            chk("acc_ready", id, 32'(rdy), 0);
            chk("acc_busy", id, 32'(bsy), 1);
            pend[id] = 1;
        end
        if (!eff) begin
            chk("hold_tx", id, 32'(tx), 32'(lvl[id]));
            return;
        end
        lvl[id] = tx;
        tsince[id]++;
        case (st[id])
            0: begin
                if (pend[id]) begin
                    chk("start_bit", id, 32'(tx), 0);
                    if (havep[id]) chk("stop_gap", id, 32'(tsince[id] >= sb + 1), 1);
                    chk("frame_busy", id, 32'(bsy), 1);
                    chk("frame_ready", id, 32'(rdy), 0);
                    pend[id] = 0; st[id] = 1; idx[id] = 0; start_cyc[id] = cyc;
                    if (qsize(id) == 0) begin
                        chk("unexpected_frame", id, 1, 0);
                        cur[id] = 8'h00;
                    end else if (id == 0) cur[id] = q0.pop_front();
                    else cur[id] = q1.pop_front();
                end else begin
                    chk("idle_tx", id, 32'(tx), 1);
                end
            end
            1: begin
                chk("mid_ready", id, 32'(rdy), 0);
                if (idx[id] < DB) begin
                    chk("data_bit", id, 32'(tx), 32'((cur[id] >> idx[id]) & 8'h01));
                    idx[id]++;
                end else begin
                    chk("stop_bit", id, 32'(tx), 1);
                    st[id] = 2; sidx[id] = 1; tsince[id] = 0;
                end
            end
            default: begin
                if (sidx[id] < sb) begin
                    chk("stop_bit", id, 32'(tx), 1);
                    chk("stop_ready", id, 32'(rdy), 0);
                    sidx[id]++;
                end else begin
                    chk("end_ready", id, 32'(rdy), 1);
                    chk("end_tx", id, 32'(tx), 1);
                    st[id] = 0; havep[id] = 1; frames[id]++;
                    last_len[id] = cyc - start_cyc[id];
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step(0, tx0, if0.READY, busy0, 1);
            mon_step(1, tx1, if1.READY, busy1, 2);
        end
    end

    // ---------------- driver ----------------
    task automatic setv(input int id, input logic v, input logic [7:0] d);
        if (id == 0) begin if0.VALID = v; if0.DATA = d; end
        else begin if1.VALID = v; if1.DATA = d; end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? if0.READY : if1.READY;
    endfunction

    task automatic send(input int id, input logic [7:0] d, input bit keep);
        int n = 0;
        @(negedge clk);
        setv(id, 1'b1, d);
        while (!rdy(id) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("send_timeout", id, 0, 1);
            setv(id, 1'b0, d);
            return;
        end
        push_exp(id, d);
        @(negedge clk);
        if (!keep) setv(id, 1'b0, d);
    endtask

    task automatic wait_done(input int id);
        int n = 0;
        while ((st[id] != 0 || pend[id] || qsize(id) != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("done_timeout", id, 0, 1);
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        mode[0] = 0; mode[1] = 0; per[0] = 4; per[1] = 3;
        setv(0, 1'b0, 8'h00);
        setv(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // 0xA5 with a tick every 4 clocks
        send(0, 8'hA5, 0);
        wait_done(0);
        chk("len_a5", 0, 32'(last_len[0]), 40);

        // tick tied high, all-zero payload
        mode[0] = 1;
        send(0, 8'h00, 0);
        wait_done(0);
        chk("len_tied", 0, 32'(last_len[0]), 10);
        mode[0] = 0;

        // acceptance on the same edge as a tick
        n = 0;
        @(negedge clk);
        while (!(tick0 && if0.READY) && n < 100) begin @(negedge clk); n++; end
        chk("coincide_found", 0, 32'(n < 100), 1);
        setv(0, 1'b1, 8'h5A);
        push_exp(0, 8'h5A);
        @(negedge clk);
        setv(0, 1'b0, 8'h5A);
        wait_done(0);

        // reset during data bit 3, then a clean frame
        send(0, 8'($urandom), 0);
        n = 0;
        while (!(st[0] == 1 && idx[0] == 4) && n < 500) begin @(negedge clk); n++; end
        chk("reach_bit3", 0, 32'(n < 500), 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        send(0, 8'($urandom), 0);
        wait_done(0);

        // two stop bits, VALID held across back-to-back words
        send(1, 8'h3C, 1);
        send(1, 8'hC3, 0);
        wait_done(1);
        chk("frames_b2b", 1, 32'(frames[1]), 2);

        // DATA/VALID disturbed while busy
        send(0, 8'h96, 0);
        n = 0;
        while (st[0] != 1 && n < 500) begin @(negedge clk); n++; end
        setv(0, 1'b1, 8'hFF);
        @(negedge clk);
        chk("busy_ready", 0, 32'(if0.READY), 0);
        setv(0, 1'b0, 8'hFF);
        wait_done(0);

        // randomized traffic and tick patterns
        for (int i = 0; i < 20; i++) begin
            mode[0] = $urandom_range(0, 2);
            per[0] = $urandom_range(1, 5);
            send(0, 8'($urandom), 0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            mode[1] = $urandom_range(0, 2);
            per[1] = $urandom_range(1, 4);
            send(1, 8'($urandom), $urandom_range(0, 1) == 1);
        end
        setv(1, 1'b0, 8'h00);
        wait_done(0);
        wait_done(1);
        chk("q0_empty", 0, 32'(q0.size()), 0);
        chk("q1_empty", 1, 32'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
